mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port, with timeout abort.
// Define ARB_ROUND_ROBIN_EN to alternate winners on collisions instead of fixed data-first priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic        dm_err,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic             owner_dm, owner_dm_d;
    logic             pick_dm;
    logic             if_gnt_d, if_valid_d, if_err_d;
    logic             dm_gnt_d, dm_valid_d, dm_err_d;
    logic [31:0]      if_rdata_d, dm_rdata_d;
    logic             mem_en_d, mem_we_d;
    logic [31:0]      mem_addr_d, mem_wdata_d;
    logic             busy_d;

    // Collision winner; owner_dm doubles as the last-granted flag for round robin.
`ifdef ARB_ROUND_ROBIN_EN
    assign pick_dm = dm_req & (~if_req | ~owner_dm);
`else
    assign pick_dm = dm_req;
`endif

    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        owner_dm_d  = owner_dm;
        if_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        dm_valid_d  = 1'b0;
        dm_err_d    = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d    = ACCESS;
                    wait_cnt_d = '0;
                    owner_dm_d = pick_dm;
                    mem_en_d   = 1'b1;
                    if (pick_dm) begin
                        dm_gnt_d    = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (!mem_ready) begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
                if (mem_ready) begin
                    state_d = RESP;
                    if (owner_dm) begin
                        dm_valid_d = 1'b1;
                        if (!mem_we) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
                    state_d = RESP;
                    if (owner_dm) begin
                        dm_valid_d = 1'b1;
                        dm_err_d   = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                        if_err_d   = 1'b1;
                    end
                end else begin
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            owner_dm  <= 1'b0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            dm_gnt    <= 1'b0;
            dm_valid  <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            owner_dm  <= owner_dm_d;
            if_gnt    <= if_gnt_d;
            if_valid  <= if_valid_d;
            if_err    <= if_err_d;
            if_rdata  <= if_rdata_d;
            dm_gnt    <= dm_gnt_d;
            dm_valid  <= dm_valid_d;
            dm_err    <= dm_err_d;
            dm_rdata  <= dm_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks plus a response scoreboard.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_valid, if_err;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_valid, dm_err;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    typedef struct {
        logic        dm;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_if = '0;
    logic [31:0] model_dm = '0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_err(if_err), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (if_valid || dm_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: if_valid=%0b dm_valid=%0b, required no response", if_valid, dm_valid);
            end else begin
                mon_e = sb.pop_front();
                if (dm_valid !== mon_e.dm || if_valid !== !mon_e.dm) begin
                    bad++;
                    $display("FAIL resp_owner: dm_valid=%0b if_valid=%0b, required dm=%0b", dm_valid, if_valid, mon_e.dm);
                end
                total++;
                if ((mon_e.dm ? dm_err : if_err) !== mon_e.err || (mon_e.dm ? if_err : dm_err) !== 1'b0) begin
                    bad++;
                    $display("FAIL resp_err: if_err=%0b dm_err=%0b, required owner err=%0b", if_err, dm_err, mon_e.err);
                end
                total++;
                if ((mon_e.dm ? dm_rdata : if_rdata) !== mon_e.rdata) begin
                    bad++;
                    $display("FAIL resp_rdata: got %h, required %h", (mon_e.dm ? dm_rdata : if_rdata), mon_e.rdata);
                end
            end
        end
    end

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: mem_en=%0b mem_we=%0b busy=%0b, required 0/0/0", mem_en, mem_we, busy);
        end
        total++;
        if ({if_gnt, dm_gnt, if_valid, dm_valid, if_err, dm_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes: %b, required 000000", {if_gnt, dm_gnt, if_valid, dm_valid, if_err, dm_err});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h dm_rdata=%h, required 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        tick();
        total++;
        if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fetch_gnt: if_gnt=%0b dm_gnt=%0b busy=%0b, required 1/0/1", if_gnt, dm_gnt, busy);
        end
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0040) begin
            bad++;
            $display("FAIL fetch_cmd: en=%0b we=%0b addr=%h, required 1/0/00000040", mem_en, mem_we, mem_addr);
        end
        if_req   = 1'b0;
        model_if = 32'h2008_0005;
        sb.push_back('{dm: 1'b0, err: 1'b0, rdata: model_if});
        tick();
        total++;
        if (if_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h0000_0040) begin
            bad++;
            $display("FAIL fetch_hold: if_gnt=%0b mem_en=%0b addr=%h, required 0/1/00000040", if_gnt, mem_en, mem_addr);
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h2008_0005;
        tick();
        mem_ready = 1'b0;
        total++;
        if (if_valid !== 1'b1 || mem_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fetch_resp: if_valid=%0b mem_en=%0b busy=%0b, required 1/0/1", if_valid, mem_en, busy);
        end
        tick();
        total++;
        if (if_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fetch_idle: if_valid=%0b busy=%0b, required 0/0", if_valid, busy);
        end
    endtask

    task automatic test_collision();
        if_addr = 32'h0000_0200;
        dm_addr = 32'h0000_0100;
        dm_we   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        tick();
        total++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h0000_0100 || busy !== 1'b1) begin
            bad++;
            $display("FAIL coll_first: dm_gnt=%0b if_gnt=%0b addr=%h busy=%0b, required 1/0/00000100/1", dm_gnt, if_gnt, mem_addr, busy);
        end
        dm_req   = 1'b0;
        model_dm = 32'h1111_2222;
        sb.push_back('{dm: 1'b1, err: 1'b0, rdata: model_dm});
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ready = 1'b0;
        total++;
        if (dm_valid !== 1'b1 || busy !== 1'b1 || if_gnt !== 1'b0) begin
            bad++;
            $display("FAIL coll_resp: dm_valid=%0b busy=%0b if_gnt=%0b, required 1/1/0", dm_valid, busy, if_gnt);
        end
        tick();
        total++;
        if (busy !== 1'b0 || if_gnt !== 1'b0) begin
            bad++;
            $display("FAIL coll_idle: busy=%0b if_gnt=%0b, required 0/0", busy, if_gnt);
        end
        tick();
        total++;
        if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || mem_addr !== 32'h0000_0200 || busy !== 1'b1) begin
            bad++;
            $display("FAIL coll_second: if_gnt=%0b dm_gnt=%0b addr=%h busy=%0b, required 1/0/00000200/1", if_gnt, dm_gnt, mem_addr, busy);
        end
        if_req   = 1'b0;
        model_if = 32'h3333_4444;
        sb.push_back('{dm: 1'b0, err: 1'b0, rdata: model_if});
        mem_ready = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_stray_ready();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || if_valid !== 1'b0 || dm_valid !== 1'b0 || if_rdata !== model_if || dm_rdata !== model_dm) begin
            bad++;
            $display("FAIL stray_ready: busy=%0b valid=%0b%0b if_rdata=%h dm_rdata=%h, required idle and unchanged", busy, if_valid, dm_valid, if_rdata, dm_rdata);
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dm_addr  = 32'h0000_0008;
        dm_wdata = 32'hDEAD_BEEF;
        dm_we    = 1'b1;
        dm_req   = 1'b1;
        tick();
        total++;
        if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h0000_0008) begin
            bad++;
            $display("FAIL store_cmd: gnt=%0b we=%0b wdata=%h addr=%h, required 1/1/deadbeef/00000008", dm_gnt, mem_we, mem_wdata, mem_addr);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        sb.push_back('{dm: 1'b1, err: 1'b0, rdata: model_dm});
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ready = 1'b0;
        total++;
        if (dm_valid !== 1'b1 || dm_rdata !== model_dm) begin
            bad++;
            $display("FAIL store_resp: dm_valid=%0b dm_rdata=%h, required 1/%h", dm_valid, dm_rdata, model_dm);
        end
        tick();
    endtask

    task automatic test_ready_at_limit();
        dm_addr = 32'h0000_0400;
        dm_req  = 1'b1;
        tick();
        dm_req = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (mem_en !== 1'b1 || dm_valid !== 1'b0) begin
            bad++;
            $display("FAIL limit_wait: mem_en=%0b dm_valid=%0b, required 1/0", mem_en, dm_valid);
        end
        model_dm = 32'h5555_6666;
        sb.push_back('{dm: 1'b1, err: 1'b0, rdata: model_dm});
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_6666;
        tick();
        mem_ready = 1'b0;
        total++;
        if (dm_valid !== 1'b1 || dm_err !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL limit_resp: dm_valid=%0b dm_err=%0b mem_en=%0b, required 1/0/0", dm_valid, dm_err, mem_en);
        end
        tick();
    endtask

    task automatic test_timeout();
        if_addr = 32'h0000_0300;
        if_req  = 1'b1;
        tick();
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL tmo_gnt: if_gnt=%0b, required 1", if_gnt);
        end
        if_req = 1'b0;
        sb.push_back('{dm: 1'b0, err: 1'b1, rdata: model_if});
        tick();
        tick();
        tick();
        total++;
        if (mem_en !== 1'b1 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_fourth: mem_en=%0b if_valid=%0b, required 1/0", mem_en, if_valid);
        end
        tick();
        total++;
        if (if_valid !== 1'b1 || if_err !== 1'b1 || mem_en !== 1'b0 || if_rdata !== model_if) begin
            bad++;
            $display("FAIL tmo_resp: valid=%0b err=%0b mem_en=%0b rdata=%h, required 1/1/0/%h", if_valid, if_err, mem_en, if_rdata, model_if);
        end
        tick();
        total++;
        if (busy !== 1'b0 || if_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_idle: busy=%0b if_err=%0b, required 0/0", busy, if_err);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_dm;
        logic seen;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0700;
        if_addr = 32'h0000_0800;
        dm_req  = 1'b1;
        if_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int w = 0; w < 8; w++) begin
                tick();
                if (if_gnt || dm_gnt) begin
                    seen = 1'b1;
                    break;
                end
            end
`ifdef ARB_ROUND_ROBIN_EN
            exp_dm = ((k % 2) == 0);
`else
            exp_dm = 1'b1;
`endif
            total++;
            if (!seen || dm_gnt !== exp_dm || if_gnt !== !exp_dm) begin
                bad++;
                $display("FAIL b2b_gnt%0d: dm_gnt=%0b if_gnt=%0b, required dm=%0b", k, dm_gnt, if_gnt, exp_dm);
            end
            total++;
            if (mem_addr !== (exp_dm ? 32'h0000_0700 : 32'h0000_0800)) begin
                bad++;
                $display("FAIL b2b_addr%0d: mem_addr=%h, required dm=%0b address", k, mem_addr, exp_dm);
            end
            if (k == 3) begin
                dm_req = 1'b0;
                if_req = 1'b0;
            end
            mem_rdata = 32'h7000_0000 | 32'(k);
            if (exp_dm) model_dm = mem_rdata;
            else        model_if = mem_rdata;
            sb.push_back('{dm: exp_dm, err: 1'b0, rdata: mem_rdata});
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0500;
        dm_req  = 1'b1;
        tick();
        dm_req = 1'b0;
        total++;
        if (dm_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rmid_gnt: dm_gnt=%0b, required 1", dm_gnt);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || dm_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async: mem_en=%0b busy=%0b dm_valid=%0b, required 0/0/0", mem_en, busy, dm_valid);
        end
        tick();
        tick();
        rst      = 1'b1;
        model_if = '0;
        model_dm = '0;
        total++;
        if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL rmid_clear: if_rdata=%h dm_rdata=%h addr=%h, required 0", if_rdata, dm_rdata, mem_addr);
        end
        if_addr = 32'h0000_0900;
        dm_addr = 32'h0000_0600;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        tick();
        total++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h0000_0600) begin
            bad++;
            $display("FAIL rmid_regrant: dm_gnt=%0b if_gnt=%0b addr=%h, required 1/0/00000600", dm_gnt, if_gnt, mem_addr);
        end
        if_req   = 1'b0;
        dm_req   = 1'b0;
        model_dm = 32'h6600_0066;
        sb.push_back('{dm: 1'b1, err: 1'b0, rdata: model_dm});
        mem_ready = 1'b1;
        mem_rdata = 32'h6600_0066;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_fetch();
        test_collision();
        test_stray_ready();
        test_store();
        test_ready_at_limit();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        tick();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
